// File: rtl/battleship_nios2_qsys_0_oci_dct_packer_if.sv
// Bus bundle for the OCI DCT packer: trace control, DCT event input,
// frame valid/ready output and observation/status signals.
interface battleship_nios2_qsys_0_oci_dct_packer_if;
  logic        trace_en;
  logic        trace_stop;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        frame_ready;
  logic        frame_valid;
  logic [33:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        test_ending;
  logic        test_has_ended;

  modport master (
    output trace_en, trace_stop, dct_valid, dct_code, frame_ready,
    input  frame_valid, frame_data, dct_buffer, dct_count, overflow,
           test_ending, test_has_ended
  );

  modport slave (
    input  trace_en, trace_stop, dct_valid, dct_code, frame_ready,
    output frame_valid, frame_data, dct_buffer, dct_count, overflow,
           test_ending, test_has_ended
  );
endinterface

// File: rtl/battleship_nios2_qsys_0_oci_dct_packer.sv
// Producer side of the OCI DCT trace path: packs 2-bit branch codes into
// 15-slot frames and hands them off through a single-entry holding register.
module battleship_nios2_qsys_0_oci_dct_packer #(
  parameter int DCT_SLOTS = 15
) (
  input  logic clk,
  input  logic jrst_n,
  battleship_nios2_qsys_0_oci_dct_packer_if.slave bus
);
  localparam int BUF_W = 2 * DCT_SLOTS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [BUF_W-1:0] pack_buf_reg, pack_buf_next;
  logic [3:0]       count_reg, count_next;
  logic             frame_valid_reg;
  logic [33:0]      frame_data_reg;
  logic             overflow_reg;

  logic accept, flush, emit, consume, drop;

  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    flush         = 1'b0;
    pack_buf_next = pack_buf_reg;
    count_next    = count_reg;

    if (state_reg == RUN) begin
      accept = bus.dct_valid && (bus.dct_code != 2'b00);
      flush  = bus.trace_stop || !bus.trace_en;
    end
    if (accept) begin
      pack_buf_next = {pack_buf_reg[BUF_W-3:0], bus.dct_code};
      count_next    = count_reg + 4'd1;
    end

    // The same-cycle event is folded into the frame before deciding to flush.
    emit    = (accept && (count_next == 4'(DCT_SLOTS))) ||
              (flush && (count_next != 4'd0));
    consume = frame_valid_reg && bus.frame_ready;
    drop    = emit && frame_valid_reg && !consume;

    case (state_reg)
      IDLE:  if (bus.trace_en) state_next = RUN;
      RUN: begin
        if (bus.trace_stop)     state_next = DRAIN;
        else if (!bus.trace_en) state_next = IDLE;
      end
      DRAIN: if (!frame_valid_reg && (count_reg == 4'd0)) state_next = DONE;
      DONE:  if (!bus.trace_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      state_reg       <= IDLE;
      pack_buf_reg    <= '0;
      count_reg       <= '0;
      frame_valid_reg <= 1'b0;
      frame_data_reg  <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (emit) begin
        pack_buf_reg <= '0;
        count_reg    <= '0;
      end else begin
        pack_buf_reg <= pack_buf_next;
        count_reg    <= count_next;
      end

      if (emit && !drop) begin
        frame_valid_reg <= 1'b1;
        frame_data_reg  <= {count_next, pack_buf_next};
      end else if (consume) begin
        frame_valid_reg <= 1'b0;
      end

      // Overflow is only raised in RUN, so it never races the IDLE->RUN clear.
      if (drop)
        overflow_reg <= 1'b1;
      else if ((state_reg == IDLE) && bus.trace_en)
        overflow_reg <= 1'b0;
    end
  end

  assign bus.frame_valid    = frame_valid_reg;
  assign bus.frame_data     = frame_data_reg;
  assign bus.dct_buffer     = pack_buf_reg;
  assign bus.dct_count      = count_reg;
  assign bus.overflow       = overflow_reg;
  assign bus.test_ending    = (state_reg == DRAIN);
  assign bus.test_has_ended = (state_reg == DONE);
endmodule

// File: tb/tb_battleship_nios2_qsys_0_oci_dct_packer.sv
// Directed and randomized checks of the DCT packer against a queue-based
// reference model of the packing, framing and trace-session rules.
module tb_battleship_nios2_qsys_0_oci_dct_packer;
  logic clk;
  logic jrst_n;

  battleship_nios2_qsys_0_oci_dct_packer_if bus ();

  battleship_nios2_qsys_0_oci_dct_packer dut (
    .clk    (clk),
    .jrst_n (jrst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: session phase, codes packed so far, holding register.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;
  int          m_phase;
  bit [1:0]    m_codes[$];
  bit          m_fv;
  bit [33:0]   m_fd;
  bit          m_ov;

  function automatic bit [29:0] packed_codes();
    bit [29:0] p = '0;
    foreach (m_codes[i]) p = (p << 2) | 30'(m_codes[i]);
    return p;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_codes.delete();
    m_fv = 1'b0;
    m_fd = '0;
    m_ov = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit stop, input bit v,
                            input bit [1:0] code, input bit rdy);
    bit in_run, acc, flush, consume, emit, old_fv;
    int old_n;
    old_fv  = m_fv;
    old_n   = m_codes.size();
    in_run  = (m_phase == PH_RUN);
    acc     = in_run && v && (code != 2'b00);
    flush   = in_run && (stop || !en);
    consume = old_fv && rdy;
    if (acc) m_codes.push_back(code);
    emit = (acc && m_codes.size() == 15) || (flush && m_codes.size() > 0);
    if (emit) begin
      if (old_fv && !consume) m_ov = 1'b1;
      else begin
        m_fv = 1'b1;
        m_fd = {4'(m_codes.size()), packed_codes()};
      end
      m_codes.delete();
    end else if (consume) begin
      m_fv = 1'b0;
    end
    case (m_phase)
      PH_IDLE:  if (en) begin m_phase = PH_RUN; m_ov = 1'b0; end
      PH_RUN:   if (stop) m_phase = PH_DRAIN; else if (!en) m_phase = PH_IDLE;
      PH_DRAIN: if (!old_fv && old_n == 0) m_phase = PH_DONE;
      default:  if (!en) m_phase = PH_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("frame_valid", 34'(bus.frame_valid), 34'(m_fv));
    chk("frame_data", bus.frame_data, m_fd);
    chk("dct_buffer", 34'(bus.dct_buffer), 34'(packed_codes()));
    chk("dct_count", 34'(bus.dct_count), 34'(m_codes.size()));
    chk("overflow", 34'(bus.overflow), 34'(m_ov));
    chk("test_ending", 34'(bus.test_ending), 34'(m_phase == PH_DRAIN));
    chk("test_has_ended", 34'(bus.test_has_ended), 34'(m_phase == PH_DONE));
  endtask

  task automatic step(input bit en, input bit stop, input bit v,
                      input bit [1:0] code, input bit rdy);
    bus.trace_en    = en;
    bus.trace_stop  = stop;
    bus.dct_valid   = v;
    bus.dct_code    = code;
    bus.frame_ready = rdy;
    @(posedge clk);
    model_step(en, stop, v, code, rdy);
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fv"}, 34'(bus.frame_valid), 34'd0);
    chk({tag, "_fd"}, bus.frame_data, 34'd0);
    chk({tag, "_buf"}, 34'(bus.dct_buffer), 34'd0);
    chk({tag, "_cnt"}, 34'(bus.dct_count), 34'd0);
    chk({tag, "_ov"}, 34'(bus.overflow), 34'd0);
    chk({tag, "_end"}, 34'(bus.test_ending), 34'd0);
    chk({tag, "_ended"}, 34'(bus.test_has_ended), 34'd0);
  endtask

  initial begin
    bus.trace_en = 0; bus.trace_stop = 0; bus.dct_valid = 0;
    bus.dct_code = 0; bus.frame_ready = 0;
    jrst_n = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    jrst_n = 1'b1;
    #4;

    // Full frame of 15 taken codes.
    step(1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 1, 2'b01, 0);
    chk("t1_frame", bus.frame_data, {4'hF, 30'h15555555});
    chk("t1_valid", 34'(bus.frame_valid), 34'd1);
    chk("t1_count", 34'(bus.dct_count), 34'd0);
    step(1, 0, 0, 2'b00, 1);

    // Partial frame flushed by trace_stop, then drain to done.
    step(1, 0, 1, 2'b01, 0);
    step(1, 0, 1, 2'b10, 0);
    step(1, 0, 1, 2'b11, 0);
    step(1, 1, 0, 2'b00, 0);
    chk("t2_frame", bus.frame_data, {4'h3, 30'h0000001B});
    chk("t2_ending", 34'(bus.test_ending), 34'd1);
    step(1, 0, 0, 2'b00, 1);
    step(1, 0, 0, 2'b00, 0);
    chk("t2_ended", 34'(bus.test_has_ended), 34'd1);
    step(0, 0, 0, 2'b00, 0);
    step(1, 0, 0, 2'b00, 0);

    // Second frame dropped while the first is held.
    for (int i = 0; i < 15; i++) step(1, 0, 1, 2'b10, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 1, 2'b11, 0);
    chk("t3_held", bus.frame_data, {4'hF, 30'h2AAAAAAA});
    chk("t3_ovf", 34'(bus.overflow), 34'd1);
    step(1, 0, 0, 2'b00, 1);
    step(0, 0, 0, 2'b00, 0);
    step(1, 0, 0, 2'b00, 0);
    chk("t3_ovf_clr", 34'(bus.overflow), 34'd0);

    // 15th event coincides with trace_stop: one full frame only.
    for (int i = 0; i < 14; i++) step(1, 0, 1, 2'b01, 0);
    step(1, 1, 1, 2'b11, 0);
    chk("t4_frame", bus.frame_data, {4'hF, 30'h15555557});
    step(1, 0, 0, 2'b00, 1);
    step(1, 0, 0, 2'b00, 0);
    chk("t4_no_empty", 34'(bus.frame_valid), 34'd0);
    chk("t4_done", 34'(bus.test_has_ended), 34'd1);
    step(0, 0, 0, 2'b00, 0);
    step(1, 0, 0, 2'b00, 0);

    // Emit on the same cycle as consume.
    for (int i = 0; i < 15; i++) step(1, 0, 1, 2'b01, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 1, 2'b10, 0);
    step(1, 0, 1, 2'b10, 1);
    chk("t5_valid", 34'(bus.frame_valid), 34'd1);
    chk("t5_frame", bus.frame_data, {4'hF, 30'h2AAAAAAA});
    chk("t5_ovf", 34'(bus.overflow), 34'd0);
    step(1, 0, 0, 2'b00, 1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 7; i++) step(1, 0, 1, 2'b01, 0);
    chk("t6_cnt7", 34'(bus.dct_count), 34'd7);
    #3;
    jrst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("t6_rst");
    #2;
    jrst_n = 1'b1;
    step(1, 0, 0, 2'b00, 0);

    // Randomized session traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 24) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
